// File: rtl/prog_loader_if.sv
// Byte-stream in / memory-write out bundle for the boot loader.
// The loader drives the memory side and status; the environment drives the UART byte and write acceptance.
interface prog_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_map_init_value;
  logic                  cpu_enable;
  logic                  load_err;
  logic                  busy;

  modport master (
    input  rx_data, rx_valid, mem_ready,
    output mem_req, mem_addr, mem_data, mem_map_init_value, cpu_enable, load_err, busy
  );

  modport slave (
    output rx_data, rx_valid, mem_ready,
    input  mem_req, mem_addr, mem_data, mem_map_init_value, cpu_enable, load_err, busy
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles big-endian words from a length-prefixed byte frame and writes them
// to memory from address 0, diverting MAP_ADDR to the register init value.
module prog_loader #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] MAP_ADDR       = ADDR_WIDTH'(30),
  parameter int                    TIMEOUT_CYCLES = 1000000
) (
  input logic           clk,
  input logic           rst_n,
  prog_loader_if.master bus
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_DATA, S_DRAIN, S_DONE, S_ERROR} state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic                  phase_q, phase_d;
  logic [7:0]            hi_q, hi_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0] map_q, map_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;

  logic                  counting;
  logic [IDLE_W-1:0]     idle_inc;
  logic                  timeout_hit;
  logic                  word_done;
  logic                  last_word;
  logic                  buf_busy;
  logic                  is_map;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  cpu_enable_o, load_err_o, busy_o;

  assign counting  = (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign idle_inc  = idle_q + IDLE_W'(1);
  // idle_q is cleared on the edge that takes a byte, so it trails elapsed cycles by one.
  assign timeout_hit = counting && !bus.rx_valid && (idle_inc == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign word_done = (state_q == S_DATA) && bus.rx_valid && phase_q;
  assign last_word = (wcnt_q == len_q - 16'd1);
  assign buf_busy  = mem_req_q && !bus.mem_ready;
  assign word_addr = ADDR_WIDTH'(wcnt_q);
  assign is_map    = (word_addr == MAP_ADDR);
  assign word_data = DATA_WIDTH'({hi_q, bus.rx_data});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (bus.rx_valid) begin
          state_d = ({len_q[15:8], bus.rx_data} == 16'd0) ? S_DONE : S_DATA;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DATA: begin
        if (word_done) begin
          if (buf_busy)       state_d = S_ERROR;
          else if (last_word) state_d = S_DRAIN;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DRAIN: begin
        if (!mem_req_q || bus.mem_ready) state_d = S_DONE;
      end
      S_DONE: state_d = S_DONE;
      S_ERROR: begin
        if (bus.rx_valid) state_d = S_LEN_LO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_enable_o = (state_q == S_DONE);
    load_err_o   = (state_q == S_ERROR);
    busy_o       = (state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_DRAIN);
  end

  always_comb begin
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    map_d      = map_q;
    idle_d     = '0;
    if (counting && !bus.rx_valid) idle_d = idle_inc;
    if (mem_req_q && bus.mem_ready) mem_req_d = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.rx_valid) begin
          len_d   = {bus.rx_data, 8'h00};
          wcnt_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid) len_d = {len_q[15:8], bus.rx_data};
      end
      S_DATA: begin
        if (bus.rx_valid && !phase_q) begin
          hi_d    = bus.rx_data;
          phase_d = 1'b1;
        end else if (word_done) begin
          phase_d = 1'b0;
          wcnt_d  = wcnt_q + 16'd1;
          // A new word may reuse the buffer in the very cycle the previous write is accepted.
          if (!buf_busy) begin
            if (is_map) begin
              map_d = word_data;
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = word_addr;
              mem_data_d = word_data;
            end
          end
        end
      end
      default: ;
    endcase
    if (state_d == S_ERROR) mem_req_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      wcnt_q     <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      map_q      <= '0;
      idle_q     <= '0;
    end else begin
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      map_q      <= map_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.mem_req            = mem_req_q;
  assign bus.mem_addr           = mem_addr_q;
  assign bus.mem_data           = mem_data_q;
  assign bus.mem_map_init_value = map_q;
  assign bus.cpu_enable         = cpu_enable_o;
  assign bus.load_err           = load_err_o;
  assign bus.busy               = busy_o;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a small memory responder logs writes, each task drives one
// scenario and compares against hand-computed values.
module tb_prog_loader;
  localparam int TO = 64;

  logic clk;
  logic rst_n;

  prog_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  prog_loader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .MAP_ADDR(16'd30), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_byte_cyc;
  int          ack_cyc;
  bit          auto_ack;
  bit          force_ready;
  bit          saw_req;
  bit          req_to_map;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [15:0] frame_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Memory controller model: acknowledges one cycle after a request is first seen.
  initial begin
    bit pend;
    pend = 1'b0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend = 1'b0;
        bus.mem_ready = 1'b0;
      end else if (!auto_ack) begin
        bus.mem_ready = force_ready;
        if (force_ready && bus.mem_req) begin
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_data);
          $display("write addr=%h data=%h", bus.mem_addr, bus.mem_data);
        end
      end else if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if (bus.mem_req) begin
        if (pend) begin
          bus.mem_ready = 1'b1;
          ack_cyc = cyc;
          pend = 1'b0;
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_data);
          $display("write addr=%h data=%h", bus.mem_addr, bus.mem_data);
        end else begin
          pend = 1'b1;
        end
      end else begin
        pend = 1'b0;
      end
      if (bus.mem_req) begin
        saw_req = 1'b1;
        if (bus.mem_addr == 16'd30) req_to_map = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    auto_ack = 1'b1;
    force_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    saw_req = 1'b0;
    req_to_map = 1'b0;
    ack_cyc = 0;
  endtask

  // Returns one cycle after the byte was taken (#1 after that edge), plus gap idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    last_byte_cyc = cyc;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] len, input int gap);
    int nb;
    nb = 2 + 2 * frame_q.size();
    for (int i = 0; i < nb; i++) begin
      logic [7:0] b;
      if (i == 0)      b = len[15:8];
      else if (i == 1) b = len[7:0];
      else if (i % 2 == 0) b = frame_q[(i - 2) / 2][15:8];
      else             b = frame_q[(i - 2) / 2][7:0];
      send_byte(b, (i == nb - 1) ? 0 : gap);
    end
  endtask

  task automatic wait_enable(input int limit, output bit seen, output int at);
    seen = 1'b0;
    at = -1;
    for (int k = 0; k < limit; k++) begin
      if (bus.cpu_enable === 1'b1) begin
        seen = 1'b1;
        at = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hFF;
    auto_ack = 1'b1;
    force_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_data, bus.mem_map_init_value,
         bus.cpu_enable, bus.load_err, bus.busy} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b addr=%h data=%h map=%h en=%b err=%b busy=%b expected all 0",
               bus.mem_req, bus.mem_addr, bus.mem_data, bus.mem_map_init_value,
               bus.cpu_enable, bus.load_err, bus.busy);
    end
    do_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.cpu_enable, bus.load_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got busy/en/err=%b expected 000", {bus.busy, bus.cpu_enable, bus.load_err});
    end
  endtask

  task automatic test_basic();
    bit seen;
    int en_cyc;
    logic [15:0] ed[3];
    ed = '{16'h1234, 16'hABCD, 16'h0001};
    do_reset();
    frame_q = '{16'h1234, 16'hABCD, 16'h0001};
    send_frame(16'd3, 1);
    wait_enable(20, seen, en_cyc);
    n_checks++;
    if (!seen || en_cyc != ack_cyc + 1) begin
      n_fail++;
      $display("FAIL basic_enable_latency: got seen=%0b cycle=%0d expected cycle=%0d", seen, en_cyc, ack_cyc + 1);
    end
    n_checks++;
    if (wr_addr.size() != 3) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d expected 3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({wr_addr[i], wr_data[i]} !== {16'(i), ed[i]}) begin
          n_fail++;
          $display("FAIL basic_write%0d: got (%h,%h) expected (%h,%h)", i, wr_addr[i], wr_data[i], 16'(i), ed[i]);
        end
      end
    end
  endtask

  task automatic test_map();
    bit seen;
    int en_cyc;
    do_reset();
    frame_q.delete();
    for (int i = 0; i < 32; i++) frame_q.push_back((i == 30) ? 16'hBEEF : 16'(i));
    send_frame(16'd32, 1);
    wait_enable(20, seen, en_cyc);
    n_checks++;
    if ({seen, bus.mem_map_init_value, req_to_map} !== {1'b1, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL map_value: got en=%b map=%h req_to_30=%b expected en=1 map=beef req_to_30=0",
               seen, bus.mem_map_init_value, req_to_map);
    end
    n_checks++;
    if (wr_addr.size() != 31) begin
      n_fail++;
      $display("FAIL map_write_count: got %0d expected 31", wr_addr.size());
    end else begin
      for (int i = 0; i < 31; i++) begin
        logic [15:0] ea;
        ea = (i < 30) ? 16'(i) : 16'(i + 1);
        n_checks++;
        if ({wr_addr[i], wr_data[i]} !== {ea, ea}) begin
          n_fail++;
          $display("FAIL map_write%0d: got (%h,%h) expected (%h,%h)", i, wr_addr[i], wr_data[i], ea, ea);
        end
      end
    end
  endtask

  task automatic test_map_last();
    do_reset();
    frame_q.delete();
    for (int i = 0; i < 31; i++) frame_q.push_back((i == 30) ? 16'hCAFE : 16'(i));
    send_frame(16'd31, 1);
    n_checks++;
    if ({bus.cpu_enable, bus.mem_map_init_value, bus.mem_req} !== {1'b0, 16'hCAFE, 1'b0}) begin
      n_fail++;
      $display("FAIL map_last_t1: got en=%b map=%h req=%b expected en=0 map=cafe req=0",
               bus.cpu_enable, bus.mem_map_init_value, bus.mem_req);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.cpu_enable, 6'(wr_addr.size())} !== {1'b1, 6'd30}) begin
      n_fail++;
      $display("FAIL map_last_t2: got en=%b writes=%0d expected en=1 writes=30", bus.cpu_enable, wr_addr.size());
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 0);
    n_checks++;
    if ({bus.busy, bus.cpu_enable} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_len_first: got busy/en=%b expected 10", {bus.busy, bus.cpu_enable});
    end
    send_byte(8'h00, 0);
    n_checks++;
    if ({bus.cpu_enable, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_len_enable: got en/busy=%b expected 10", {bus.cpu_enable, bus.busy});
    end
    send_byte(8'hAA, 3);
    send_byte(8'h55, 3);
    n_checks++;
    if ({bus.cpu_enable, bus.busy, saw_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL zero_len_done: got en/busy/saw_req=%b expected 100", {bus.cpu_enable, bus.busy, saw_req});
    end
  endtask

  task automatic test_overrun();
    do_reset();
    auto_ack = 1'b0;
    send_byte(8'h00, 3);
    send_byte(8'h04, 3);
    send_byte(8'h11, 3);
    send_byte(8'h22, 0);
    n_checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_data} !== {1'b1, 16'h0000, 16'h1122}) begin
      n_fail++;
      $display("FAIL overrun_first_req: got req=%b addr=%h data=%h expected 1 0000 1122",
               bus.mem_req, bus.mem_addr, bus.mem_data);
    end
    repeat (3) @(posedge clk);
    #1;
    send_byte(8'h33, 3);
    n_checks++;
    if ({bus.load_err, bus.mem_req} !== 2'b01) begin
      n_fail++;
      $display("FAIL overrun_half_word: got err/req=%b expected 01", {bus.load_err, bus.mem_req});
    end
    send_byte(8'h44, 0);
    n_checks++;
    if ({bus.load_err, bus.mem_req, bus.cpu_enable, bus.busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL overrun_error: got err/req/en/busy=%b expected 1000",
               {bus.load_err, bus.mem_req, bus.cpu_enable, bus.busy});
    end
    repeat (24) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.load_err, bus.cpu_enable, saw_req, 5'(wr_addr.size())} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL overrun_hold: got err=%b en=%b writes=%0d expected err=1 en=0 writes=0",
               bus.load_err, bus.cpu_enable, wr_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    auto_ack = 1'b0;
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'h56, 1);
    force_ready = 1'b1;
    send_byte(8'h78, 0);
    force_ready = 1'b0;
    n_checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_data, bus.load_err} !== {1'b1, 16'h0001, 16'h5678, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_reload: got req=%b addr=%h data=%h err=%b expected 1 0001 5678 0",
               bus.mem_req, bus.mem_addr, bus.mem_data, bus.load_err);
    end
    force_ready = 1'b1;
    @(posedge clk);
    #1;
    force_ready = 1'b0;
    n_checks++;
    if ({bus.cpu_enable, bus.mem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_done: got en/req=%b expected 10", {bus.cpu_enable, bus.mem_req});
    end
    n_checks++;
    if (wr_addr.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_write_count: got %0d expected 2", wr_addr.size());
    end else begin
      n_checks++;
      if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {16'h0000, 16'h1234, 16'h0001, 16'h5678}) begin
        n_fail++;
        $display("FAIL b2b_writes: got (%h,%h)(%h,%h) expected (0000,1234)(0001,5678)",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_timeout();
    int t0;
    int err_cyc;
    bit seen;
    int en_cyc;
    do_reset();
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'h12, 0);
    t0 = last_byte_cyc;
    err_cyc = -1;
    for (int k = 0; k < TO + 20; k++) begin
      if (bus.load_err === 1'b1) begin
        err_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (err_cyc != t0 + TO) begin
      n_fail++;
      $display("FAIL timeout_latency: got load_err at +%0d expected +%0d", err_cyc - t0, TO);
    end
    n_checks++;
    if ({bus.busy, bus.cpu_enable, bus.mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_state: got busy/en/req=%b expected 000", {bus.busy, bus.cpu_enable, bus.mem_req});
    end
    send_byte(8'h00, 0);
    n_checks++;
    if ({bus.load_err, bus.busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_recover: got err/busy=%b expected 01", {bus.load_err, bus.busy});
    end
    send_byte(8'h01, 1);
    send_byte(8'h55, 1);
    send_byte(8'h66, 0);
    wait_enable(20, seen, en_cyc);
    n_checks++;
    if (!seen || wr_addr.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_reload: got en=%b writes=%0d expected en=1 writes=1", seen, wr_addr.size());
    end else begin
      n_checks++;
      if ({wr_addr[0], wr_data[0]} !== {16'h0000, 16'h5566}) begin
        n_fail++;
        $display("FAIL timeout_write: got (%h,%h) expected (0000,5566)", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    int en_cyc;
    do_reset();
    send_byte(8'h00, 1);
    send_byte(8'h03, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 0);
    n_checks++;
    if ({bus.mem_req, bus.busy, bus.mem_data} !== {1'b1, 1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL areset_pre: got req=%b busy=%b data=%h expected 1 1 1234", bus.mem_req, bus.busy, bus.mem_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_data, bus.mem_map_init_value,
         bus.cpu_enable, bus.load_err, bus.busy} !== 52'd0) begin
      n_fail++;
      $display("FAIL areset_outputs: got req=%b addr=%h data=%h map=%h en=%b err=%b busy=%b expected all 0",
               bus.mem_req, bus.mem_addr, bus.mem_data, bus.mem_map_init_value,
               bus.cpu_enable, bus.load_err, bus.busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    frame_q = '{16'h1234, 16'hABCD, 16'h0001};
    send_frame(16'd3, 1);
    wait_enable(20, seen, en_cyc);
    n_checks++;
    if (!seen || wr_addr.size() != 3) begin
      n_fail++;
      $display("FAIL areset_reload: got en=%b writes=%0d expected en=1 writes=3", seen, wr_addr.size());
    end else begin
      n_checks++;
      if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]} !==
          {16'h0000, 16'h1234, 16'h0001, 16'hABCD, 16'h0002, 16'h0001}) begin
        n_fail++;
        $display("FAIL areset_writes: got (%h,%h)(%h,%h)(%h,%h) expected (0000,1234)(0001,abcd)(0002,0001)",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_map();
    test_map_last();
    test_zero_len();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
